// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-code, state and control-word definitions for the control sequencer.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LD      = 3'd2,
    CLS_ST      = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  typedef struct packed {
    logic       run;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       pcin;
    logic       pcout;
    logic       irin;
    logic       yin;
    logic       zin;
    logic       marin;
    logic       mdrin;
    logic       mdrout;
    logic       incpc;
    logic       zlowout;
    logic       cout;
    logic       read;
    logic       write;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the sequencer's instruction/handshake inputs and datapath control outputs.
interface control_sequencer_if;

  logic [31:0] ir;
  logic        stop;
  logic        mem_ready;
  logic        run;
  logic        gra, grb, grc;
  logic        rin, rout, baout;
  logic        pcin, pcout, irin, yin, zin;
  logic        marin, mdrin, mdrout, incpc, zlowout, cout;
  logic        read, write;
  logic [3:0]  alu_op;

  modport master (
    output ir, stop, mem_ready,
    input  run, gra, grb, grc, rin, rout, baout, pcin, pcout, irin, yin, zin,
    input  marin, mdrin, mdrout, incpc, zlowout, cout, read, write, alu_op
  );

  modport slave (
    input  ir, stop, mem_ready,
    output run, gra, grb, grc, rin, rout, baout, pcin, pcout, irin, yin, zin,
    output marin, mdrin, mdrout, incpc, zlowout, cout, read, write, alu_op
  );

endinterface

// File: rtl/ir_decode.sv
// Opcode to instruction-class and ALU-operation decoder.
module ir_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e instr_class,
  output logic [3:0]   alu_op
);

  // opcode classification; address arithmetic for addi/ld/st uses ADD
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_NONE;
    case (opcode)
      OP_ADD:  begin instr_class = CLS_ALU;  alu_op = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_ALU;  alu_op = ALU_SUB; end
      OP_AND:  begin instr_class = CLS_ALU;  alu_op = ALU_AND; end
      OP_OR:   begin instr_class = CLS_ALU;  alu_op = ALU_OR;  end
      OP_ADDI: begin instr_class = CLS_ADDI; alu_op = ALU_ADD; end
      OP_LD:   begin instr_class = CLS_LD;   alu_op = ALU_ADD; end
      OP_ST:   begin instr_class = CLS_ST;   alu_op = ALU_ADD; end
      OP_HALT: begin instr_class = CLS_HALT; alu_op = ALU_NONE; end
      default: begin instr_class = CLS_ILLEGAL; alu_op = ALU_NONE; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer (fetch / execute / halt) for a simple CPU datapath.
// Define CTRL_MEM_WAIT_EN to make T1, ld-T6 and st-T7 hold until mem_ready.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  input  logic        mem_ready,
  output logic        run,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        pcin,
  output logic        pcout,
  output logic        irin,
  output logic        yin,
  output logic        zin,
  output logic        marin,
  output logic        mdrin,
  output logic        mdrout,
  output logic        incpc,
  output logic        zlowout,
  output logic        cout,
  output logic        read,
  output logic        write,
  output logic [3:0]  alu_op
);

  state_e       state_q, state_d;
  state_e       next_fetch_s;
  instr_class_e cls_s;
  logic [3:0]   dec_alu_s;
  logic         mem_hold_s;
  logic         mem_xfer_s;
  logic         sig_unused_s;
  ctrl_t        ctrl_s;

  ir_decode u_ir_decode (
    .opcode      (ir[31:27]),
    .instr_class (cls_s),
    .alu_op      (dec_alu_s)
  );

  assign next_fetch_s = stop ? S_HALTED : S_T0;
  assign mem_xfer_s   = (state_q == S_T1) ||
                        ((state_q == S_T6) && (cls_s == CLS_LD)) ||
                        ((state_q == S_T7) && (cls_s == CLS_ST));

`ifdef CTRL_MEM_WAIT_EN
  assign mem_hold_s   = mem_xfer_s && !mem_ready;
  assign sig_unused_s = ^ir[26:0];
`else
  assign mem_hold_s   = 1'b0;
  assign sig_unused_s = ^{ir[26:0], mem_ready, mem_xfer_s};
`endif

  // state register, cleared straight to IDLE by clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: every path back to T0 is diverted to HALTED while stop is high
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = next_fetch_s;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_hold_s) state_d = S_T1;
        else            state_d = S_T2;
      end
      S_T2: begin
        case (cls_s)
          CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST: state_d = S_T3;
          CLS_HALT:                          state_d = S_HALTED;
          default:                           state_d = next_fetch_s;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) state_d = S_T6;
        else                                        state_d = next_fetch_s;
      end
      S_T6: begin
        if (mem_hold_s) state_d = S_T6;
        else            state_d = S_T7;
      end
      S_T7: begin
        if (mem_hold_s) state_d = S_T7;
        else            state_d = next_fetch_s;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and instruction class
  always_comb begin
    ctrl_s = '0;
    case (state_q)
      S_T0: begin
        ctrl_s.run = 1'b1; ctrl_s.pcout = 1'b1; ctrl_s.marin = 1'b1;
        ctrl_s.incpc = 1'b1; ctrl_s.zin = 1'b1;
      end
      S_T1: begin
        ctrl_s.run = 1'b1; ctrl_s.zlowout = 1'b1; ctrl_s.pcin = 1'b1;
        ctrl_s.read = 1'b1; ctrl_s.mdrin = 1'b1;
      end
      S_T2: begin
        ctrl_s.run = 1'b1; ctrl_s.mdrout = 1'b1; ctrl_s.irin = 1'b1;
      end
      S_T3: begin
        ctrl_s.run = 1'b1; ctrl_s.grb = 1'b1; ctrl_s.yin = 1'b1;
        if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) ctrl_s.baout = 1'b1;
        else                                        ctrl_s.rout  = 1'b1;
      end
      S_T4: begin
        ctrl_s.run = 1'b1; ctrl_s.zin = 1'b1; ctrl_s.alu_op = dec_alu_s;
        if (cls_s == CLS_ALU) begin
          ctrl_s.grc = 1'b1; ctrl_s.rout = 1'b1;
        end else begin
          ctrl_s.cout = 1'b1;
        end
      end
      S_T5: begin
        ctrl_s.run = 1'b1; ctrl_s.zlowout = 1'b1;
        if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) begin
          ctrl_s.marin = 1'b1;
        end else begin
          ctrl_s.gra = 1'b1; ctrl_s.rin = 1'b1;
        end
      end
      S_T6: begin
        ctrl_s.run = 1'b1; ctrl_s.mdrin = 1'b1;
        if (cls_s == CLS_LD) begin
          ctrl_s.read = 1'b1;
        end else begin
          ctrl_s.gra = 1'b1; ctrl_s.rout = 1'b1;
        end
      end
      S_T7: begin
        ctrl_s.run = 1'b1;
        if (cls_s == CLS_LD) begin
          ctrl_s.mdrout = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rin = 1'b1;
        end else begin
          ctrl_s.write = 1'b1;
        end
      end
      default: ctrl_s = '0;
    endcase
  end

  assign run     = ctrl_s.run;
  assign gra     = ctrl_s.gra;
  assign grb     = ctrl_s.grb;
  assign grc     = ctrl_s.grc;
  assign rin     = ctrl_s.rin;
  assign rout    = ctrl_s.rout;
  assign baout   = ctrl_s.baout;
  assign pcin    = ctrl_s.pcin;
  assign pcout   = ctrl_s.pcout;
  assign irin    = ctrl_s.irin;
  assign yin     = ctrl_s.yin;
  assign zin     = ctrl_s.zin;
  assign marin   = ctrl_s.marin;
  assign mdrin   = ctrl_s.mdrin;
  assign mdrout  = ctrl_s.mdrout;
  assign incpc   = ctrl_s.incpc;
  assign zlowout = ctrl_s.zlowout;
  assign cout    = ctrl_s.cout;
  assign read    = ctrl_s.read;
  assign write   = ctrl_s.write;
  assign alu_op  = ctrl_s.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction output tables checked every cycle.
module tb_control_sequencer;

`ifdef CTRL_MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
  localparam int LD_LEN   = 14;
`else
  localparam bit MEM_WAIT = 1'b0;
  localparam int LD_LEN   = 8;
`endif

  localparam logic [23:0] RUN     = 24'h800000;
  localparam logic [23:0] GRA     = 24'h400000;
  localparam logic [23:0] GRB     = 24'h200000;
  localparam logic [23:0] GRC     = 24'h100000;
  localparam logic [23:0] RIN     = 24'h080000;
  localparam logic [23:0] ROUT    = 24'h040000;
  localparam logic [23:0] BAOUT   = 24'h020000;
  localparam logic [23:0] PCIN    = 24'h010000;
  localparam logic [23:0] PCOUT   = 24'h008000;
  localparam logic [23:0] IRIN    = 24'h004000;
  localparam logic [23:0] YIN     = 24'h002000;
  localparam logic [23:0] ZIN     = 24'h001000;
  localparam logic [23:0] MARIN   = 24'h000800;
  localparam logic [23:0] MDRIN   = 24'h000400;
  localparam logic [23:0] MDROUT  = 24'h000200;
  localparam logic [23:0] INCPC   = 24'h000100;
  localparam logic [23:0] ZLOWOUT = 24'h000080;
  localparam logic [23:0] COUT    = 24'h000040;
  localparam logic [23:0] READ    = 24'h000020;
  localparam logic [23:0] WRITE   = 24'h000010;

  localparam logic [4:0] T_LD = 5'b00000, T_ST = 5'b00010, T_ADD = 5'b00011, T_SUB = 5'b00100;
  localparam logic [4:0] T_AND = 5'b00101, T_OR = 5'b00110, T_ADDI = 5'b01100, T_HALT = 5'b11011;
  localparam logic [4:0] T_BAD = 5'b11111;

  typedef struct {
    logic [23:0] vec;
    bit          mem;
  } step_t;

  logic        clk;
  logic        clr;
  logic [23:0] dut_vec;
  logic [23:0] exp_vec;
  bit          exp_valid;
  int          n_tests, n_fail;
  int          since_t0, write_cnt, rin_cnt, zin_x_cnt;
  step_t       seq_q[$];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(bus.ir), .stop(bus.stop), .mem_ready(bus.mem_ready),
    .run(bus.run), .gra(bus.gra), .grb(bus.grb), .grc(bus.grc),
    .rin(bus.rin), .rout(bus.rout), .baout(bus.baout),
    .pcin(bus.pcin), .pcout(bus.pcout), .irin(bus.irin), .yin(bus.yin), .zin(bus.zin),
    .marin(bus.marin), .mdrin(bus.mdrin), .mdrout(bus.mdrout), .incpc(bus.incpc),
    .zlowout(bus.zlowout), .cout(bus.cout), .read(bus.read), .write(bus.write),
    .alu_op(bus.alu_op)
  );

  assign dut_vec = {bus.run, bus.gra, bus.grb, bus.grc, bus.rin, bus.rout, bus.baout,
                    bus.pcin, bus.pcout, bus.irin, bus.yin, bus.zin, bus.marin, bus.mdrin,
                    bus.mdrout, bus.incpc, bus.zlowout, bus.cout, bus.read, bus.write,
                    bus.alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // compare process: outputs against the model every cycle, plus event counters
  always @(negedge clk) begin
    if (exp_valid) chk("cycle", dut_vec, exp_vec);
    if (bus.pcout) since_t0 = 1;
    else           since_t0 = since_t0 + 1;
    write_cnt = write_cnt + int'(bus.write);
    rin_cnt   = rin_cnt + int'(bus.rin);
    zin_x_cnt = zin_x_cnt + int'(bus.zin && !bus.pcout);
  end

  function automatic step_t mk(input logic [23:0] v, input bit m);
    step_t s;
    s.vec = v;
    s.mem = m;
    return s;
  endfunction

  // model: the cycle-by-cycle control words an opcode must produce
  task automatic build(input logic [4:0] op);
    logic [23:0] aop;
    seq_q.delete();
    seq_q.push_back(mk(RUN | PCOUT | MARIN | INCPC | ZIN, 1'b0));
    seq_q.push_back(mk(RUN | ZLOWOUT | PCIN | READ | MDRIN, 1'b1));
    seq_q.push_back(mk(RUN | MDROUT | IRIN, 1'b0));
    aop = {20'd0, op[3:0]};
    if (op == T_ADD || op == T_SUB || op == T_AND || op == T_OR) begin
      seq_q.push_back(mk(RUN | GRB | ROUT | YIN, 1'b0));
      seq_q.push_back(mk(RUN | GRC | ROUT | ZIN | aop, 1'b0));
      seq_q.push_back(mk(RUN | ZLOWOUT | GRA | RIN, 1'b0));
    end else if (op == T_ADDI) begin
      seq_q.push_back(mk(RUN | GRB | ROUT | YIN, 1'b0));
      seq_q.push_back(mk(RUN | COUT | ZIN | 24'd3, 1'b0));
      seq_q.push_back(mk(RUN | ZLOWOUT | GRA | RIN, 1'b0));
    end else if (op == T_LD || op == T_ST) begin
      seq_q.push_back(mk(RUN | GRB | BAOUT | YIN, 1'b0));
      seq_q.push_back(mk(RUN | COUT | ZIN | 24'd3, 1'b0));
      seq_q.push_back(mk(RUN | ZLOWOUT | MARIN, 1'b0));
      if (op == T_LD) begin
        seq_q.push_back(mk(RUN | READ | MDRIN, 1'b1));
        seq_q.push_back(mk(RUN | MDROUT | GRA | RIN, 1'b0));
      end else begin
        seq_q.push_back(mk(RUN | GRA | ROUT | MDRIN, 1'b0));
        seq_q.push_back(mk(RUN | WRITE, 1'b1));
      end
    end
  endtask

  task automatic do_reset();
    clr = 1'b0;
    bus.stop = 1'b0;
    exp_vec = 24'd0;
    exp_valid = 1'b1;
    #1 chk("reset_low", dut_vec, 24'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [4:0] op, input int wait_n, input int stop_from,
                      input int clr_step, input int pin_step, input logic [23:0] pin_vec);
    int reps;
    build(op);
    bus.ir = {op, 27'($urandom)};
    for (int i = 0; i < seq_q.size(); i++) begin
      reps = (MEM_WAIT && seq_q[i].mem) ? wait_n + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        exp_vec = seq_q[i].vec;
        bus.stop = (stop_from >= 0) && (i >= stop_from);
        bus.mem_ready = seq_q[i].mem && MEM_WAIT && (r == reps - 1);
        if (i == pin_step && r == 0) begin
          #1 chk("pinned_word", dut_vec, pin_vec);
        end
        if (i == clr_step && r == 0) begin
          #1 clr = 1'b0;
          exp_vec = 24'd0;
          #1 chk("clr_async", dut_vec, 24'd0);
          @(posedge clk);
          #1 clr = 1'b1;
          @(posedge clk);
          #1 bus.stop = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    int w0, r0, z0;
    n_tests = 0; n_fail = 0;
    since_t0 = 0; write_cnt = 0; rin_cnt = 0; zin_x_cnt = 0;
    bus.ir = 32'd0; bus.stop = 1'b0; bus.mem_ready = 1'b0;
    clr = 1'b0; exp_vec = 24'd0; exp_valid = 1'b1;
    do_reset();
    chk("t0_after_reset", dut_vec, RUN | PCOUT | MARIN | INCPC | ZIN);

    exec(T_ADD, 0, -1, -1, 4, 24'h941003);
    chk_int("add_len", since_t0, 6);
    chk("add_back_t0", {23'd0, bus.pcout}, 24'd1);
    exec(T_SUB, 0, -1, -1, 4, 24'h941004);
    exec(T_AND, 0, -1, -1, -1, 24'd0);
    exec(T_ADDI, 0, -1, -1, -1, 24'd0);
    chk_int("addi_len", since_t0, 6);

    exec(T_LD, 3, -1, -1, -1, 24'd0);
    chk_int("ld_len", since_t0, LD_LEN);

    w0 = write_cnt;
    exec(T_ST, 0, -1, -1, 6, 24'hC40400);
    chk_int("st_len", since_t0, 8);
    chk_int("st_write_cycles", write_cnt - w0, 1);

    r0 = rin_cnt; z0 = zin_x_cnt;
    exec(T_BAD, 0, -1, -1, -1, 24'd0);
    chk_int("bad_len", since_t0, 3);
    chk_int("bad_rin", rin_cnt - r0, 0);
    chk_int("bad_zin", zin_x_cnt - z0, 0);

    exec(T_LD, 1, -1, 6, -1, 24'd0);
    chk("t0_after_clr", dut_vec, RUN | PCOUT | MARIN | INCPC | ZIN);
    exec(T_ADD, 0, -1, -1, -1, 24'd0);

    exec(T_OR, 0, 3, -1, 4, 24'h941006);
    for (int k = 0; k < 20; k++) begin
      exp_vec = 24'd0;
      bus.stop = k[0];
      bus.mem_ready = k[1];
      @(posedge clk);
      #1;
    end
    chk("halted_run", {23'd0, bus.run}, 24'd0);

    do_reset();
    exec(T_HALT, 0, -1, -1, -1, 24'd0);
    for (int k = 0; k < 5; k++) begin
      exp_vec = 24'd0;
      @(posedge clk);
      #1;
    end
    do_reset();
    exec(T_ADD, 0, -1, -1, -1, 24'd0);
    exp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk  in  1  single system clock.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents. Opcode is ir[31:27].
- stop  in  1  halt request.
- mem_ready  in  1  memory completion.
- run  out  1  processor running.
- gra, grb, grc  out  1 each  register-field selects.
- rin, rout, baout  out  1 each  selected-register in, out and base-address out.
- pcin, pcout, irin, yin, zin  out  1 each  datapath register enables.
- marin, mdrin, mdrout, incpc, zlowout, cout  out  1 each  datapath register enables.
- read, write  out  1 each  memory strobes.
- alu_op  out  4  ALU operation code.

REQ-002 The block SHALL be a single clock domain on clk, with reset asynchronous and active-low on clr.

Function
REQ-003 All outputs SHALL be a combinational Moore decode of the state register and ir. No output SHALL depend on stop or mem_ready.

REQ-004 The states SHALL be IDLE, T0 to T7 and HALTED.

REQ-005 IDLE SHALL drive every output to 0 and SHALL go to T0 on the next clock edge.

REQ-006 Fetch SHALL be three states:
- T0: pcout, marin, incpc, zin.
- T1: zlowout, pcin, read, mdrin.
- T2: mdrout, irin.

REQ-007 At the end of T2, the opcode SHALL select the next step:
- add 00011, sub 00100, and 00101, or 00110, addi 01100, ld 00000, st 00010 → T3.
- halt 11011 → HALTED.
- any other opcode → T0, treated as a no-op.

REQ-008 Register-register ALU instructions (add, sub, and, or) SHALL be:
- T3: grb, rout, yin.
- T4: grc, rout, alu_op = the opcode's operation, zin.
- T5: zlowout, gra, rin, then → T0.

REQ-009 addi SHALL be:
- T3: grb, rout, yin.
- T4: cout, alu_op = ADD, zin.
- T5: zlowout, gra, rin, then → T0.

REQ-010 ld and st SHALL share these states:
- T3: grb, baout, yin.
- T4: cout, alu_op = ADD, zin.
- T5: zlowout, marin.

REQ-011 ld SHALL then be:
- T6: read, mdrin.
- T7: mdrout, gra, rin, then → T0.

REQ-012 st SHALL then be:
- T6: gra, rout, mdrin, with read = 0.
- T7: write, then → T0.

REQ-013 In every state other than T4, alu_op SHALL be 0000.

REQ-014 A full instruction SHALL take:
- 6 cycles for an ALU instruction or addi.
- 8 cycles for ld or st.
- 3 cycles for an illegal opcode.

REQ-015 When stop = 1 on the clock edge that would enter T0, the state SHALL enter HALTED instead. stop SHALL be ignored in all other states.

REQ-016 HALTED SHALL drive run = 0 and all other outputs to 0, and SHALL be left only by reset.

REQ-017 run SHALL be 1 in states T0 to T7 and 0 in IDLE and HALTED.

Reset
REQ-018 Asserting clr (low) SHALL force IDLE immediately and asynchronously, from any state including mid-instruction or mid-wait. All outputs SHALL read 0 while clr is low.

REQ-019 After clr is released, T0 SHALL be entered on the second rising edge: IDLE for one cycle, then T0.

Configuration
REQ-020 When CTRL_MEM_WAIT_EN is defined:
- T1, ld-T6 and st-T7 SHALL hold their state, with outputs unchanged, until mem_ready = 1.
- The state SHALL advance on the edge where mem_ready = 1.

REQ-021 When CTRL_MEM_WAIT_EN is undefined, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-022 Package cpu_pkg SHALL hold:
- the 5-bit opcode constants;
- the 4-bit alu_op encodings: ADD 0011, SUB 0100, AND 0101, OR 0110, NONE 0000;
- the state enumeration.

REQ-023 Sub-module ir_decode SHALL map the opcode to an instruction class (ALU, ADDI, LD, ST, HALT, ILLEGAL) and to an alu_op. The sequencer SHALL instantiate it once.

Verification
REQ-024 Reset release, then add (ir = 0x18000000 | fields) → states IDLE, T0 to T5, back at T0 on cycle 7, with alu_op = 0011 only in T4.

REQ-025 ld with CTRL_MEM_WAIT_EN defined and mem_ready held low 3 cycles in T1 and in T6 → 14 cycles from T0 to the next T0, with read held constant across each wait.

REQ-026 st → mdrin and rout are high in T6, read is low in T6, and write is high for exactly one cycle in T7.

REQ-027 Opcode 11111 → T0, T1, T2, then T0, with no rin and no zin pulse.

REQ-028 stop raised during T3 of an or → T4 and T5 complete, then HALTED with run = 0, and the state stays HALTED for 20 further cycles.

REQ-029 clr pulsed low during T6 of an ld → all outputs drop to 0 that same cycle, then IDLE, then T0 after release.
